// File: rtl/whack_pkg.sv
// Shared display types and helpers: conversion FSM states, blank pattern and
// the active-low seven-segment decode (bit 0 = segment a ... bit 6 = segment g).
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one shift per cycle.
module bin2bcd_seq
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  value_i,
  output logic [11:0] bcd_o,
  output logic        busy_o,
  output logic        done_o,
  output conv_state_t state_o
);

  // Handshake: start_i is taken only in IDLE; abort_i reloads value_i from any
  // state; done_o is high for the single DONE cycle, when bcd_o holds the result.
  conv_state_t state_q;
  logic [7:0]  bin_q;
  logic [11:0] acc_q;
  logic [11:0] acc_d;
  logic [2:0]  cnt_q;
  logic        busy_q;

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < 3; i++) begin
      acc_d[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                   : acc_q[4*i +: 4];
    end
    acc_d = {acc_d[10:0], bin_q[7]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (abort_i || (state_q == IDLE && start_i)) begin
      state_q <= SHIFT;
      bin_q   <= value_i;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= {bin_q[6:0], 1'b0};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_o   = acc_q;
  assign busy_o  = busy_q;
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Score display: source selection and record keeping, BCD conversion, digit
// scan with leading-zero blanking, and new-record blink.
module score_display_ctrl
  import whack_pkg::*;
#(
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLINK_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] score,
  input  logic       game_end,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] digit_en,
  output logic [7:0] high_score,
  output logic       new_record,
  output logic       busy
);

  localparam int DCW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic           ge_q, rec_q, final_req_q, dp_q;
  logic [7:0]     final_q, last_q, high_q;
  logic [11:0]    disp_q, conv_bcd;
  logic [DCW-1:0] scan_q;
  logic [BCW-1:0] blink_q;
  logic [1:0]     idx_q;
  logic [6:0]     seg_q, seg_d;
  logic [2:0]     den_q;
  logic           conv_busy, conv_done, live_req, conv_start, blink_on, blink_dark;
  logic           dp_d, blank;
  logic [3:0]     digit_val;
  logic [7:0]     conv_val;
  conv_state_t    conv_state;

  // A final score always wins: it aborts whatever is in flight.
  assign live_req   = (conv_state == IDLE) && !game_end && (score != last_q) && !final_req_q;
  assign conv_start = final_req_q || live_req;
  assign conv_val   = final_req_q ? final_q : score;
  assign blink_on   = game_end && rec_q;
  assign blink_dark = blink_on && (blink_q >= BCW'(BLINK_CYCLES / 2));

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .abort_i (final_req_q),
    .value_i (conv_val),
    .bcd_o   (conv_bcd),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .state_o (conv_state)
  );

  always_comb begin
    digit_val = disp_q[3:0];
    blank     = 1'b0;
    case (idx_q)
      2'd1: begin
        digit_val = disp_q[7:4];
        blank     = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit_val = disp_q[11:8];
        blank     = (disp_q[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg_d = (blank || blink_dark) ? SEG_BLANK : seg7(digit_val);
    dp_d  = !((idx_q == 2'd0) && blink_on && !blink_dark);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ge_q        <= 1'b0;
      rec_q       <= 1'b0;
      final_req_q <= 1'b0;
      final_q     <= '0;
      last_q      <= '0;
      high_q      <= '0;
      disp_q      <= '0;
      scan_q      <= '0;
      idx_q       <= '0;
      blink_q     <= '0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      den_q       <= 3'b000;
    end else begin
      ge_q        <= game_end;
      final_req_q <= game_end && !ge_q;
      if (game_end && !ge_q) begin
        final_q <= score;
        rec_q   <= (score > high_q);
        if (score > high_q) high_q <= score;
      end else if (!game_end && ge_q) begin
        rec_q <= 1'b0;
      end
      if (conv_start) last_q <= conv_val;
      if (conv_done)  disp_q <= conv_bcd;

      if (scan_q == DCW'(DIGIT_CYCLES - 1)) begin
        scan_q <= '0;
        idx_q  <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + DCW'(1);
      end

      if (!blink_on)                             blink_q <= '0;
      else if (blink_q == BCW'(BLINK_CYCLES - 1)) blink_q <= '0;
      else                                        blink_q <= blink_q + BCW'(1);

      seg_q <= seg_d;
      dp_q  <= dp_d;
      den_q <= 3'b001 << idx_q;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = den_q;
  assign high_score = high_q;
  assign new_record = rec_q;
  assign busy       = conv_busy;

endmodule
